okwireout_bank: RTL and testbench

Parametrised bank of Wire Out endpoints occupying consecutive host addresses in the 0x20–0x3F range. All channels are captured together on each host wire-update, so the host reads a coherent snapshot. Each channel is either a level sample or a sticky-OR event accumulator. An optional status channel reports a capture counter. The bank sits on the okHE/okEH host bus alongside the other endpoints, and its okEH output is OR-combined with theirs.

---
 rtl/okwireout_bank_pkg.sv | 16 +
 rtl/okwireout_bank_chan.sv | 46 ++++
 rtl/okwireout_bank.sv | 94 +++++++++
 tb/tb_okwireout_bank.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/okwireout_bank_pkg.sv
// Shared constants for the Wire Out bank: okHE/okEH field positions and the legal
// address window for wire-out endpoints.
package okwireout_bank_pkg;

  localparam logic [7:0] WIRE_ADDR_MIN = 8'h20;
  localparam logic [7:0] WIRE_ADDR_MAX = 8'h3F;
  localparam int         WIRE_W        = 32;

  localparam int HE_W          = 113;
  localparam int EH_W          = 65;
  localparam int HE_RESET      = 1;
  localparam int HE_ADDR_LSB   = 4;
  localparam int HE_ADDR_W     = 8;
  localparam int HE_WIREUPDATE = 44;

endpackage

// File: rtl/okwireout_bank_chan.sv
// One wire-out channel: a hold register, plus an OR accumulator when the channel
// is in sticky mode so events between captures are never lost.
module okwireout_chan
  import okwireout_bank_pkg::*;
#(
  parameter bit STICKY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst,
  input  logic              capture,
  input  logic [WIRE_W-1:0] din,
  output logic [WIRE_W-1:0] hold
);

  if (STICKY) begin : g_sticky
    logic [WIRE_W-1:0] acc;

    // Bits seen in the capture cycle go into this snapshot, not the next one.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc  <= '0;
        hold <= '0;
      end else if (srst) begin
        acc  <= '0;
        hold <= '0;
      end else if (capture) begin
        hold <= acc | din;
        acc  <= '0;
      end else begin
        acc <= acc | din;
      end
    end
  end else begin : g_level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold <= '0;
      end else if (srst) begin
        hold <= '0;
      end else if (capture) begin
        hold <= din;
      end
    end
  end

endmodule

// File: rtl/okwireout_bank.sv
// Bank of Wire Out endpoints at consecutive host addresses, captured together on
// each wire-update so the host always reads a coherent snapshot.
module okwireout_bank
  import okwireout_bank_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter logic [7:0]      BASE_ADDR   = 8'h20,
  parameter logic [N_CH-1:0] STICKY_MASK = '0,
  parameter bit              STATUS_EN   = 1'b0
) (
  input  logic                   ti_clk,
  input  logic                   ti_reset_n,
  input  logic [HE_W-1:0]        okHE,
  output logic [EH_W-1:0]        okEH,
  input  logic [WIRE_W*N_CH-1:0] ep_datain,
  output logic                   ep_captured
);

  localparam int         LAST_ADDR   = int'(BASE_ADDR) + N_CH - 1 + (STATUS_EN ? 1 : 0);
  localparam logic [7:0] STATUS_ADDR = 8'(int'(BASE_ADDR) + N_CH);

  if (BASE_ADDR < WIRE_ADDR_MIN || LAST_ADDR > int'(WIRE_ADDR_MAX) || N_CH < 1) begin : g_range_err
    $error("okwireout_bank: endpoint addresses fall outside the 0x20-0x3F wire-out range");
  end

  logic                 srst;
  logic                 capture;
  logic [HE_ADDR_W-1:0] ti_addr;
  logic                 unused_he;

  assign srst      = okHE[HE_RESET];
  assign capture   = okHE[HE_WIREUPDATE];
  assign ti_addr   = okHE[HE_ADDR_LSB +: HE_ADDR_W];
  assign unused_he = ^okHE;

  logic [WIRE_W-1:0] hold [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    okwireout_chan #(
      .STICKY (STICKY_MASK[k])
    ) u_chan (
      .clk     (ti_clk),
      .rst_n   (ti_reset_n),
      .srst    (srst),
      .capture (capture),
      .din     (ep_datain[WIRE_W*k +: WIRE_W]),
      .hold    (hold[k])
    );
  end

  logic [WIRE_W-1:0] status_hold;

  if (STATUS_EN) begin : g_status
    logic [WIRE_W-1:0] cnt;

    // Status reports the capture count including the capture that loaded it.
    always_ff @(posedge ti_clk or negedge ti_reset_n) begin
      if (!ti_reset_n) begin
        cnt         <= '0;
        status_hold <= '0;
      end else if (srst) begin
        cnt         <= '0;
        status_hold <= '0;
      end else if (capture) begin
        cnt         <= cnt + 1'b1;
        status_hold <= cnt + 1'b1;
      end
    end
  end else begin : g_no_status
    assign status_hold = '0;
  end

  always_ff @(posedge ti_clk or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      ep_captured <= 1'b0;
    end else begin
      ep_captured <= capture & ~srst;
    end
  end

  logic [WIRE_W-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ti_addr == 8'(int'(BASE_ADDR) + k)) rd_data = hold[k];
    end
    if (STATUS_EN && ti_addr == STATUS_ADDR) rd_data = status_hold;
  end

  // READY and REGREADDATA stay zero: this endpoint never drives register reads.
  assign okEH = {32'd0, 1'b0, rd_data};

endmodule

// File: tb/tb_okwireout_bank.sv
// Self-checking bench for okwireout_bank: 4 channels (1 and 3 sticky) with status,
// randomized stimulus compared against a snapshot/event reference model.
module tb_okwireout_bank;

  localparam int         N_CH   = 4;
  localparam logic [7:0] BASE   = 8'h20;
  localparam logic [3:0] STICKY = 4'b1010;

  logic         ti_clk = 1'b0;
  logic         ti_reset_n = 1'b0;
  logic [112:0] okHE;
  logic [64:0]  okEH;
  logic [127:0] ep_datain;
  logic         ep_captured;

  logic        wu = 1'b0;
  logic        srst = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] din [N_CH];

  assign okHE      = {68'd0, wu, 32'd0, addr, 2'b00, srst, 1'b0};
  assign ep_datain = {din[3], din[2], din[1], din[0]};

  always #10 ti_clk = ~ti_clk;

  okwireout_bank #(
    .N_CH        (N_CH),
    .BASE_ADDR   (BASE),
    .STICKY_MASK (STICKY),
    .STATUS_EN   (1'b1)
  ) dut (
    .ti_clk      (ti_clk),
    .ti_reset_n  (ti_reset_n),
    .okHE        (okHE),
    .okEH        (okEH),
    .ep_datain   (ep_datain),
    .ep_captured (ep_captured)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: snapshot per channel, pending events per sticky channel,
  // and a plain count of accepted captures.
  logic [31:0] m_snap [N_CH];
  logic [31:0] m_pend [N_CH];
  logic [31:0] m_count;
  logic [31:0] m_status;
  logic        m_cap;

  function automatic void model_clear();
    for (int k = 0; k < N_CH; k++) begin
      m_snap[k] = 0;
      m_pend[k] = 0;
    end
    m_count  = 0;
    m_status = 0;
    m_cap    = 0;
  endfunction

  function automatic logic [64:0] exp_rd(input logic [7:0] a);
    logic [31:0] d;
    d = 0;
    if (a >= BASE && a < BASE + N_CH) d = m_snap[a - BASE];
    else if (a == BASE + N_CH) d = m_status;
    return {33'd0, d};
  endfunction

  task automatic step(input bit wu_i, input bit srst_i);
    wu   = wu_i;
    srst = srst_i;
    @(posedge ti_clk);
    if (!ti_reset_n || srst_i) begin
      model_clear();
    end else if (wu_i) begin
      for (int k = 0; k < N_CH; k++) begin
        m_snap[k] = STICKY[k] ? (m_pend[k] | din[k]) : din[k];
        m_pend[k] = 0;
      end
      m_count  = m_count + 1;
      m_status = m_count;
      m_cap    = 1;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (STICKY[k]) m_pend[k] = m_pend[k] | din[k];
      m_cap = 0;
    end
    #1;
    wu   = 1'b0;
    srst = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [64:0] d);
    addr = a;
    #1;
    d = okEH;
  endtask

  task automatic test_reset();
    logic [64:0] d;
    model_clear();
    for (int k = 0; k < N_CH; k++) din[k] = $urandom;
    ti_reset_n = 1'b0;
    step(1'b1, 1'b0);
    for (int a = 8'h1F; a <= 8'h26; a++) begin
      rd(8'(a), d);
      n_checks++;
      if (d !== 65'd0) begin
        n_fail++;
        $display("FAIL reset_read addr=%h actual=%h required=0", a, d);
      end
    end
    n_checks++;
    if (ep_captured !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_captured actual=%b required=0", ep_captured);
    end
    #3 ti_reset_n = 1'b1;
  endtask

  task automatic test_level_snapshot();
    logic [64:0] d;
    for (int k = 0; k < N_CH; k++) din[k] = 32'h11111111 * (k + 1);
    step(1'b1, 1'b0);
    n_checks++;
    if (ep_captured !== 1'b1) begin
      n_fail++;
      $display("FAIL level_captured_pulse actual=%b required=1", ep_captured);
    end
    for (int a = 8'h20; a <= 8'h23; a++) begin
      rd(8'(a), d);
      n_checks++;
      if (d !== {33'd0, 32'h11111111 * (a - 8'h1F)}) begin
        n_fail++;
        $display("FAIL level_read addr=%h actual=%h required=%h", a, d, 32'h11111111 * (a - 8'h1F));
      end
    end
    rd(8'h24, d);
    n_checks++;
    if (d !== 65'd1) begin
      n_fail++;
      $display("FAIL level_status actual=%h required=1", d);
    end
    rd(8'h25, d);
    n_checks++;
    if (d !== 65'd0) begin
      n_fail++;
      $display("FAIL level_out_of_range actual=%h required=0", d);
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (ep_captured !== 1'b0) begin
      n_fail++;
      $display("FAIL level_captured_once actual=%b required=0", ep_captured);
    end
  endtask

  task automatic test_sticky();
    logic [64:0] d;
    for (int k = 0; k < N_CH; k++) din[k] = 0;
    step(1'b1, 1'b0);
    din[1] = 32'h1; step(1'b0, 1'b0);
    din[1] = 32'h2; step(1'b0, 1'b0);
    din[1] = 32'h4; step(1'b0, 1'b0);
    din[1] = 32'h8; step(1'b1, 1'b0);
    din[1] = 32'h0;
    rd(8'h21, d);
    n_checks++;
    if (d !== 65'h0000000F) begin
      n_fail++;
      $display("FAIL sticky_accum actual=%h required=0000000f", d);
    end
    step(1'b1, 1'b0);
    rd(8'h21, d);
    n_checks++;
    if (d !== 65'd0) begin
      n_fail++;
      $display("FAIL sticky_cleared actual=%h required=0", d);
    end
  endtask

  task automatic test_coherency();
    logic [64:0] d;
    logic [31:0] snap [N_CH];
    for (int cyc = 1; cyc <= 14; cyc++) begin
      for (int k = 0; k < N_CH; k++) din[k] = $urandom;
      if (cyc == 10) for (int k = 0; k < N_CH; k++) snap[k] = din[k];
      step(cyc == 10, 1'b0);
      if (cyc >= 10) begin
        for (int k = 0; k < N_CH; k++) begin
          rd(8'(BASE + k), d);
          n_checks++;
          if (d !== exp_rd(8'(BASE + k)) || (!STICKY[k] && d[31:0] !== snap[k])) begin
            n_fail++;
            $display("FAIL coherency cyc=%0d ch=%0d actual=%h required=%h", cyc, k, d, exp_rd(8'(BASE + k)));
          end
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    logic [64:0] d;
    @(negedge ti_clk);
    force dut.g_status.cnt = 32'hFFFFFFFE;
    #1 release dut.g_status.cnt;
    m_count = 32'hFFFFFFFE;
    step(1'b1, 1'b0);
    rd(8'h24, d);
    n_checks++;
    if (d !== 65'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL wrap_first actual=%h required=ffffffff", d);
    end
    step(1'b1, 1'b0);
    rd(8'h24, d);
    n_checks++;
    if (d !== 65'd0) begin
      n_fail++;
      $display("FAIL wrap_second actual=%h required=0", d);
    end
  endtask

  task automatic test_sync_reset_vs_capture();
    logic [64:0] d;
    for (int k = 0; k < N_CH; k++) din[k] = $urandom | 32'h1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int a = 8'h20; a <= 8'h24; a++) begin
      rd(8'(a), d);
      n_checks++;
      if (d !== 65'd0) begin
        n_fail++;
        $display("FAIL srst_vs_capture addr=%h actual=%h required=0", a, d);
      end
    end
    n_checks++;
    if (ep_captured !== 1'b0) begin
      n_fail++;
      $display("FAIL srst_captured actual=%b required=0", ep_captured);
    end
  endtask

  task automatic test_async_reset();
    logic [64:0] d;
    for (int k = 0; k < N_CH; k++) din[k] = $urandom | 32'h80000000;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #2 ti_reset_n = 1'b0;
    model_clear();
    for (int a = 8'h20; a <= 8'h24; a++) begin
      rd(8'(a), d);
      n_checks++;
      if (d !== 65'd0) begin
        n_fail++;
        $display("FAIL async_reset addr=%h actual=%h required=0", a, d);
      end
    end
    step(1'b0, 1'b0);
    #3 ti_reset_n = 1'b1;
    for (int k = 0; k < N_CH; k++) din[k] = $urandom;
    step(1'b1, 1'b0);
    for (int a = 8'h20; a <= 8'h24; a++) begin
      rd(8'(a), d);
      n_checks++;
      if (d !== exp_rd(8'(a))) begin
        n_fail++;
        $display("FAIL post_reset_capture addr=%h actual=%h required=%h", a, d, exp_rd(8'(a)));
      end
    end
  endtask

  task automatic test_random();
    logic [64:0] d;
    logic [7:0]  ra;
    for (int cyc = 0; cyc < 150; cyc++) begin
      for (int k = 0; k < N_CH; k++) din[k] = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
      n_checks++;
      if (ep_captured !== m_cap) begin
        n_fail++;
        $display("FAIL rand_captured cyc=%0d actual=%b required=%b", cyc, ep_captured, m_cap);
      end
      for (int a = 8'h1F; a <= 8'h25; a++) begin
        rd(8'(a), d);
        n_checks++;
        if (d !== exp_rd(8'(a))) begin
          n_fail++;
          $display("FAIL rand_read cyc=%0d addr=%h actual=%h required=%h", cyc, a, d, exp_rd(8'(a)));
        end
      end
      ra = 8'($urandom);
      rd(ra, d);
      n_checks++;
      if (d !== exp_rd(ra)) begin
        n_fail++;
        $display("FAIL rand_any_addr addr=%h actual=%h required=%h", ra, d, exp_rd(ra));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N_CH; k++) din[k] = 0;
    test_reset();
    test_level_snapshot();
    test_sticky();
    test_coherency();
    test_counter_wrap();
    test_sync_reset_vs_capture();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
